cayde_writeback: RTL and testbench
==================================

// Module: cayde_writeback
// PURPOSE
// - Writeback stage: sole driver of the cayde_regfile write port (waddr_in/wdata_in/wen_in).
// - Merges ALU results and load responses onto the single port, with one registered stage.
// - Aligns and sign- or zero-extends load data, and suppresses writes to x0.
// - Keeps a pending-load scoreboard that decode queries to stall on RAW hazards.
// - Exports the registered write as a bypass source.
// PARAMETERS
// - XLEN     32  datapath width
// - REG_AW   5   register address width (32 architectural registers)
// PORTS
// - clk            in   1       clock, rising edge
// - rst_n          in   1       asynchronous, active-low reset
// - alu_valid      in   1       ALU result available
// - alu_ready      out  1       ALU result accepted this cycle
// - alu_rd         in   REG_AW  ALU destination register
// - alu_data       in   XLEN    ALU result
// - ld_valid       in   1       load response available
// - ld_ready       out  1       load response accepted; tied 1
// - ld_rd          in   REG_AW  load destination register
// - ld_data        in   XLEN    raw aligned memory word
// - ld_funct3      in   3       load type: LB=000 LH=001 LW=010 LBU=100 LHU=101
// - ld_addr_lo     in   2       byte offset of the load address
// - iss_ld_valid   in   1       decode issues a load this cycle
// - iss_ld_rd      in   REG_AW  destination register of the issued load
// - rs1_q, rs2_q   in   REG_AW  decode source registers
// - rs1_busy       out  1       rs1_q has a pending load (combinational)
// - rs2_busy       out  1       rs2_q has a pending load (combinational)
// - wen_out        out  1       regfile write enable
// - waddr_out      out  REG_AW  regfile write address
// - wdata_out      out  XLEN    regfile write data
// - err_ld         out  1       sticky flag: bad load response
// BEHAVIOUR
// - Reset (async, rst_n=0) drives these values:
//   - wen_out=0, waddr_out=0, wdata_out=0, err_ld=0.
//   - pending[31:0]=0.
//   - The stage accepts nothing while reset is asserted.
//   - An in-flight write is dropped.
// - Arbitration uses fixed priority, load over ALU.
//   - alu_ready = !ld_valid; ld_ready = 1.
//   - Result: at most one accept per cycle.
// - Latency is one cycle. An input accepted at edge N appears on wen_out/waddr_out/wdata_out
//   for exactly cycle N+1. No backpressure from the regfile.
// - wen_out=0 under any of these conditions:
//   - no input is accepted;
//   - the accepted rd is 0;
//   - the load is invalid.
//   waddr_out and wdata_out hold their last values while wen_out=0.
// - Load extension (sub-module):
//   - LB/LBU select byte ld_addr_lo. LH/LHU select halfword ld_addr_lo[1].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
// - An invalid load is a misaligned LH/LHU (addr_lo[0]=1), a misaligned LW (addr_lo!=0),
//   or an undefined funct3. For an invalid load:
//   - no write;
//   - err_ld is set and stays set until reset;
//   - the pending bit is still cleared.
// - Scoreboard update:
//   - An issue with rd!=0 sets pending[rd].
//   - An accepted load clears pending[ld_rd].
//   - If set and clear target the same rd in one cycle, set wins.
//   - pending[0] is always 0.
// - A load response whose rd is not pending still writes (if valid) and sets err_ld.
// - rs1_busy = pending[rs1_q]; rs2_busy = pending[rs2_q].
//   - Clearing a bit is visible in the cycle after acceptance, aligned with wen_out.
//   - Decode must use the bypass for the write cycle itself.
// STRUCTURE
// - cayde_pkg holds:
//   - localparams for the load funct3 codes (F3_LB..F3_LHU);
//   - XLEN and REG_AW defaults.
// - Sub-module cayde_load_align: combinational, inputs (data, funct3, addr_lo), outputs
//   (ext_data, misalign).
// - The top level holds the arbiter, the output register, the pending bitmap and err_ld.
// TESTING
// - ALU alone, rd=5, data=0xDEADBEEF, accepted at edge N:
//   - alu_ready=1;
//   - in cycle N+1, wen_out=1, waddr_out=5, wdata_out=0xDEADBEEF.
//   - ALU write with rd=0 -> wen_out stays 0.
// - ALU rd=3 and load rd=4 valid in the same cycle:
//   - ld wins; alu_ready=0; the ALU holds its inputs;
//   - the next cycles write x4, then x3.
// - Load extension, ld_data=0x80F0_7F81:
//   - LB off0 -> 0xFFFFFF81; LBU off0 -> 0x00000081; LB off1 -> 0x0000007F;
//   - LH off2 -> 0xFFFF80F0; LHU off2 -> 0x000080F0; LW off0 -> 0x80F07F81.
// - Issue a load to rd=7:
//   - rs1_q=7 -> rs1_busy=1;
//   - response accepted at N -> busy clears at N+1;
//   - issue rd=7 again in the same cycle as the response -> busy stays 1.
// - Misaligned or rogue loads:
//   - LH with addr_lo=1 -> no write, err_ld=1, and err_ld stays 1;
//   - load response to a non-pending rd -> err_ld=1.
// - Reset asserted mid-write (wen_out=1) -> all outputs and the pending bitmap are 0
//   immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cayde_pkg.sv
// Shared constants for the cayde writeback slice: datapath defaults and load funct3 codes.
package cayde_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/cayde_load_align.sv
// Combinational load formatter: picks the byte/halfword addressed by addr_lo and extends it.
// misalign also covers undefined funct3 codes, so the caller treats it as "invalid load".
module cayde_load_align
    import cayde_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ext_data,
    output logic            misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = data[{addr_lo, 3'b000} +: 8];
    assign sel_half = data[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        ext_data = '0;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  ext_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_LBU: ext_data = {{(XLEN-8){1'b0}}, sel_byte};
            F3_LH: begin
                ext_data = {{(XLEN-16){sel_half[15]}}, sel_half};
                misalign = addr_lo[0];
            end
            F3_LHU: begin
                ext_data = {{(XLEN-16){1'b0}}, sel_half};
                misalign = addr_lo[0];
            end
            F3_LW: begin
                ext_data = data;
                misalign = (addr_lo != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/cayde_writeback.sv
// Writeback stage: arbitrates loads over ALU results onto the single regfile write port,
// registers the write, and tracks pending loads for decode hazard checks.
module cayde_writeback
    import cayde_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic              iss_ld_valid,
    input  logic [REG_AW-1:0] iss_ld_rd,
    input  logic [REG_AW-1:0] rs1_q,
    input  logic [REG_AW-1:0] rs2_q,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              wen_out,
    output logic [REG_AW-1:0] waddr_out,
    output logic [XLEN-1:0]   wdata_out,
    output logic              err_ld
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic [XLEN-1:0] ld_ext;
    logic            ld_misalign;
    logic            ld_write;
    logic            alu_write;
    logic            ld_bad;

    cayde_load_align #(.XLEN(XLEN)) u_align (
        .data     (ld_data),
        .funct3   (ld_funct3),
        .addr_lo  (ld_addr_lo),
        .ext_data (ld_ext),
        .misalign (ld_misalign)
    );

    assign ld_ready  = 1'b1;
    assign alu_ready = !ld_valid;
    assign rs1_busy  = pending[rs1_q];
    assign rs2_busy  = pending[rs2_q];

    assign ld_write  = ld_valid && !ld_misalign && (ld_rd != '0);
    assign alu_write = alu_valid && !ld_valid && (alu_rd != '0);
    // A response that is malformed or was never issued is flagged, but still retires the bit.
    assign ld_bad    = ld_valid && (ld_misalign || !pending[ld_rd]);

    // Issue is applied after the clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        pending_nxt = pending;
        if (ld_valid) begin
            pending_nxt[ld_rd] = 1'b0;
        end
        if (iss_ld_valid) begin
            pending_nxt[iss_ld_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_out   <= 1'b0;
            waddr_out <= '0;
            wdata_out <= '0;
            err_ld    <= 1'b0;
            pending   <= '0;
        end else begin
            wen_out <= ld_write || alu_write;
            if (ld_write) begin
                waddr_out <= ld_rd;
                wdata_out <= ld_ext;
            end else if (alu_write) begin
                waddr_out <= alu_rd;
                wdata_out <= alu_data;
            end
            if (ld_bad) begin
                err_ld <= 1'b1;
            end
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_cayde_writeback.sv
// Self-checking bench for cayde_writeback: directed literal cases, then randomized traffic
// checked every cycle against a behavioural model of the writeback rules.
module tb_cayde_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_addr_lo = '0;
    logic        iss_ld_valid = 1'b0;
    logic [4:0]  iss_ld_rd = '0;
    logic [4:0]  rs1_q = '0;
    logic [4:0]  rs2_q = '0;
    logic        rs1_busy, rs2_busy;
    logic        wen_out;
    logic [4:0]  waddr_out;
    logic [31:0] wdata_out;
    logic        err_ld;

    int n_vec = 0;
    int n_err = 0;

    cayde_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .iss_ld_valid(iss_ld_valid), .iss_ld_rd(iss_ld_rd),
        .rs1_q(rs1_q), .rs2_q(rs2_q), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wen_out(wen_out), .waddr_out(waddr_out), .wdata_out(wdata_out), .err_ld(err_ld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules for load formatting, written as plain arithmetic.
    function automatic bit ld_ok(input int f3, input int off);
        case (f3)
            0, 4:    return 1'b1;
            1, 5:    return (off % 2) == 0;
            2:       return off == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] d, input int f3, input int off);
        int v;
        v = 0;
        case (f3)
            0, 4: begin
                v = int'((d >> (8 * off)) & 32'hFF);
                if (f3 == 0 && v > 127) v = v - 256;
            end
            1, 5: begin
                v = int'((d >> (16 * (off / 2))) & 32'hFFFF);
                if (f3 == 1 && v > 32767) v = v - 65536;
            end
            2: v = int'(d);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    // Behavioural model state
    bit          m_pend [32];
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wen  <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            m_err  <= 1'b0;
            for (int r = 0; r < 32; r++) m_pend[r] <= 1'b0;
        end else begin
            if (ld_valid) begin
                if (ld_ok(int'(ld_funct3), int'(ld_addr_lo)) && ld_rd != 0) begin
                    m_wen  <= 1'b1;
                    m_addr <= ld_rd;
                    m_data <= ld_val(ld_data, int'(ld_funct3), int'(ld_addr_lo));
                end else begin
                    m_wen <= 1'b0;
                end
                if (!ld_ok(int'(ld_funct3), int'(ld_addr_lo)) || !m_pend[ld_rd]) m_err <= 1'b1;
            end else if (alu_valid && alu_rd != 0) begin
                m_wen  <= 1'b1;
                m_addr <= alu_rd;
                m_data <= alu_data;
            end else begin
                m_wen <= 1'b0;
            end
            for (int r = 1; r < 32; r++) begin
                if (iss_ld_valid && int'(iss_ld_rd) == r) m_pend[r] <= 1'b1;
                else if (ld_valid && int'(ld_rd) == r)    m_pend[r] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_wen", {31'b0, wen_out}, {31'b0, m_wen});
            chk("m_waddr", {27'b0, waddr_out}, {27'b0, m_addr});
            chk("m_wdata", wdata_out, m_data);
            chk("m_err", {31'b0, err_ld}, {31'b0, m_err});
            chk("m_rs1_busy", {31'b0, rs1_busy}, {31'b0, m_pend[rs1_q]});
            chk("m_rs2_busy", {31'b0, rs2_busy}, {31'b0, m_pend[rs2_q]});
            chk("m_alu_ready", {31'b0, alu_ready}, {31'b0, !ld_valid});
            chk("m_ld_ready", {31'b0, ld_ready}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid = 1'b0;
        iss_ld_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] d);
        iss_ld_valid = 1'b1; iss_ld_rd = rd;
        tick();
        iss_ld_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = off; ld_data = d;
        tick();
        idle();
        @(negedge clk);
    endtask

    localparam logic [31:0] PAT = 32'h80F0_7F81;

    initial begin
        // Pin the reference model itself
        chk("mdl_lb0", ld_val(PAT, 0, 0), 32'hFFFFFF81);
        chk("mdl_lh2", ld_val(PAT, 1, 2), 32'hFFFF80F0);
        chk("mdl_lhu2", ld_val(PAT, 5, 2), 32'h000080F0);
        chk("mdl_ok_lh1", {31'b0, ld_ok(1, 1)}, 32'd0);

        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wen", {31'b0, wen_out}, 32'd0);
        chk("rst_err", {31'b0, err_ld}, 32'd0);
        chk("rst_wdata", wdata_out, 32'd0);

        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 chk("alu_ready", {31'b0, alu_ready}, 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("alu_wen", {31'b0, wen_out}, 32'd1);
        chk("alu_waddr", {27'b0, waddr_out}, 32'd5);
        chk("alu_wdata", wdata_out, 32'hDEADBEEF);

        tick();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        tick();
        idle();
        @(negedge clk);
        chk("alu_x0_wen", {31'b0, wen_out}, 32'd0);
        chk("alu_x0_hold", wdata_out, 32'hDEADBEEF);

        // Priority: load over ALU
        tick();
        iss_ld_valid = 1'b1; iss_ld_rd = 5'd4;
        tick();
        iss_ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010; ld_addr_lo = 2'd0; ld_data = 32'h44;
        #1 chk("prio_alu_ready", {31'b0, alu_ready}, 32'd0);
        tick();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("prio_first", {27'b0, waddr_out}, 32'd4);
        chk("prio_first_d", wdata_out, 32'h44);
        tick();
        idle();
        @(negedge clk);
        chk("prio_second", {27'b0, waddr_out}, 32'd3);
        chk("prio_second_d", wdata_out, 32'h33);

        // Load extension
        tick(); do_load(5'd10, 3'b000, 2'd0, PAT); chk("ext_lb0", wdata_out, 32'hFFFFFF81);
        tick(); do_load(5'd10, 3'b100, 2'd0, PAT); chk("ext_lbu0", wdata_out, 32'h00000081);
        tick(); do_load(5'd10, 3'b000, 2'd1, PAT); chk("ext_lb1", wdata_out, 32'h0000007F);
        tick(); do_load(5'd10, 3'b001, 2'd2, PAT); chk("ext_lh2", wdata_out, 32'hFFFF80F0);
        tick(); do_load(5'd10, 3'b101, 2'd2, PAT); chk("ext_lhu2", wdata_out, 32'h000080F0);
        tick(); do_load(5'd10, 3'b010, 2'd0, PAT); chk("ext_lw0", wdata_out, 32'h80F07F81);
        chk("ext_no_err", {31'b0, err_ld}, 32'd0);

        // Scoreboard on rd=7
        tick();
        rs1_q = 5'd7;
        iss_ld_valid = 1'b1; iss_ld_rd = 5'd7;
        tick();
        iss_ld_valid = 1'b0;
        @(negedge clk);
        chk("sb_busy", {31'b0, rs1_busy}, 32'd1);
        tick();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_addr_lo = 2'd0; ld_data = 32'h77;
        tick();
        idle();
        @(negedge clk);
        chk("sb_clear", {31'b0, rs1_busy}, 32'd0);
        chk("sb_clear_wen", {31'b0, wen_out}, 32'd1);
        tick();
        iss_ld_valid = 1'b1; iss_ld_rd = 5'd7;
        tick();
        ld_valid = 1'b1; ld_rd = 5'd7;
        tick();
        idle();
        @(negedge clk);
        chk("sb_set_wins", {31'b0, rs1_busy}, 32'd1);
        tick();
        ld_valid = 1'b1; ld_rd = 5'd7;
        tick();
        idle();

        // Misaligned LH
        tick(); do_load(5'd11, 3'b001, 2'd1, PAT);
        chk("mis_wen", {31'b0, wen_out}, 32'd0);
        chk("mis_err", {31'b0, err_ld}, 32'd1);
        rs2_q = 5'd11;
        #1 chk("mis_cleared", {31'b0, rs2_busy}, 32'd0);
        tick(); tick(); tick();
        chk("mis_sticky", {31'b0, err_ld}, 32'd1);

        // Reset mid-write with a pending bit set
        iss_ld_valid = 1'b1; iss_ld_rd = 5'd9; rs1_q = 5'd9;
        tick();
        iss_ld_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hCAFE;
        tick();
        idle();
        chk("pre_rst_wen", {31'b0, wen_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_wen", {31'b0, wen_out}, 32'd0);
        chk("arst_waddr", {27'b0, waddr_out}, 32'd0);
        chk("arst_wdata", wdata_out, 32'd0);
        chk("arst_err", {31'b0, err_ld}, 32'd0);
        chk("arst_busy", {31'b0, rs1_busy}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Rogue load to non-pending rd
        tick();
        ld_valid = 1'b1; ld_rd = 5'd12; ld_funct3 = 3'b010; ld_addr_lo = 2'd0; ld_data = 32'hABCD;
        tick();
        idle();
        @(negedge clk);
        chk("rogue_err", {31'b0, err_ld}, 32'd1);
        chk("rogue_wen", {31'b0, wen_out}, 32'd1);

        // Randomized traffic, small register range to force hazards
        for (int i = 0; i < 4000; i++) begin
            tick();
            alu_valid    = ($urandom_range(0, 1) == 1);
            alu_rd       = 5'($urandom_range(0, 7));
            alu_data     = $urandom;
            ld_valid     = ($urandom_range(0, 2) == 0);
            ld_rd        = 5'($urandom_range(0, 7));
            ld_data      = $urandom;
            ld_funct3    = 3'($urandom_range(0, 7));
            ld_addr_lo   = 2'($urandom_range(0, 3));
            iss_ld_valid = ($urandom_range(0, 2) == 0);
            iss_ld_rd    = 5'($urandom_range(0, 7));
            rs1_q        = 5'($urandom_range(0, 7));
            rs2_q        = 5'($urandom_range(0, 7));
            if (i == 2000) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        tick();
        idle();
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
